// File: rtl/rv_decode_stage.sv
// RV32I decode stage: OP-IMM/OP/LUI/AUIPC decode, bypass resolution,
// load-use bubbles and an ID/EX register behind a valid/ready handshake.
module rv_decode_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [31:0]             inst_i,
  output logic [4:0]              rs1_addr_o,
  output logic [4:0]              rs2_addr_o,
  input  logic [XLEN-1:0]         rs1_data_i,
  input  logic [XLEN-1:0]         rs2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg_i,
  input  logic [NUM_FWD-1:0]      fwd_is_load_i,
  input  logic [NUM_FWD*5-1:0]    fwd_wd_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_wdata_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [XLEN-1:0]         pc_o,
  output logic [3:0]              aluop_o,
  output logic [XLEN-1:0]         op1_o,
  output logic [XLEN-1:0]         op2_o,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic                    illegal_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2;
  localparam logic [3:0] A_SLL = 4'd3, A_SLT = 4'd4, A_SLTU = 4'd5;
  localparam logic [3:0] A_XOR = 4'd6, A_SRL = 4'd7, A_SRA = 4'd8;
  localparam logic [3:0] A_OR  = 4'd9, A_AND = 4'd10;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];
  assign rs1 = inst_i[19:15];
  assign rs2 = inst_i[24:20];
  assign rd  = inst_i[11:7];

  assign rs1_addr_o = rst ? 5'd0 : rs1;
  assign rs2_addr_o = rst ? 5'd0 : rs2;

  // Returns {is_load, data}; walking down makes index 0 win ties.
  function automatic logic [XLEN:0] fwd_sel(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf
  );
    logic [XLEN:0] r;
    r = {1'b0, rf};
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_wreg_i[i] && fwd_wd_i[i*5 +: 5] == rs)
        r = {fwd_is_load_i[i], fwd_wdata_i[i*XLEN +: XLEN]};
    end
    if (rs == 5'd0) r = '0;
    return r;
  endfunction

  function automatic logic [3:0] f3_op(
    input logic [2:0] fn,
    input logic       alt
  );
    logic [3:0] r;
    unique case (fn)
      3'b000:  r = alt ? A_SUB : A_ADD;
      3'b001:  r = A_SLL;
      3'b010:  r = A_SLT;
      3'b011:  r = A_SLTU;
      3'b100:  r = A_XOR;
      3'b101:  r = alt ? A_SRA : A_SRL;
      3'b110:  r = A_OR;
      default: r = A_AND;
    endcase
    return r;
  endfunction

  logic [XLEN:0]   fw1, fw2;
  logic            use1, use2, legal, hazard, accept;
  logic [3:0]      aluop_d;
  logic [XLEN-1:0] op1_d, op2_d;

  assign fw1 = fwd_sel(rs1, rs1_data_i);
  assign fw2 = fwd_sel(rs2, rs2_data_i);

  always_comb begin
    use1    = 1'b0;
    use2    = 1'b0;
    legal   = 1'b0;
    aluop_d = A_NOP;
    op1_d   = '0;
    op2_d   = '0;
    unique case (1'b1)
      opc == OPC_OPIMM: begin
        use1  = 1'b1;
        op1_d = fw1[XLEN-1:0];
        op2_d = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
        unique case (f3)
          3'b001:  legal = (f7 == 7'b0000000);
          3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
        // Shifts take the 5-bit shamt, not the sign-extended immediate.
        if (f3 == 3'b001 || f3 == 3'b101)
          op2_d = {{(XLEN-5){1'b0}}, inst_i[24:20]};
        aluop_d = f3_op(f3, f3 == 3'b101 && f7[5]);
      end
      opc == OPC_OP: begin
        use1    = 1'b1;
        use2    = 1'b1;
        op1_d   = fw1[XLEN-1:0];
        op2_d   = fw2[XLEN-1:0];
        legal   = (f7 == 7'b0000000) ||
                  (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        aluop_d = f3_op(f3, f7[5]);
      end
      opc == OPC_LUI: begin
        legal   = 1'b1;
        op2_d   = {{(XLEN-32){1'b0}}, inst_i[31:12], 12'b0};
        aluop_d = A_ADD;
      end
      opc == OPC_AUIPC: begin
        legal   = 1'b1;
        op1_d   = pc_i;
        op2_d   = {{(XLEN-32){1'b0}}, inst_i[31:12], 12'b0};
        aluop_d = A_ADD;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) aluop_d = A_NOP;
  end

  assign hazard = in_valid_i &&
                  ((use1 && fw1[XLEN]) || (use2 && fw2[XLEN]));

  logic drain;
  assign drain      = !out_valid_o || out_ready_i;
  assign in_ready_o = !rst && !flush_i && !hazard && drain;
  assign accept     = in_valid_i && in_ready_o;

  logic            valid_q, wreg_q, illegal_q;
  logic [XLEN-1:0] pc_q, op1_q, op2_q;
  logic [3:0]      aluop_q;
  logic [4:0]      wd_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      wreg_q    <= 1'b0;
      illegal_q <= 1'b0;
      pc_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      aluop_q   <= '0;
      wd_q      <= '0;
      cnt_q     <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      pc_q      <= pc_i;
      aluop_q   <= aluop_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      wd_q      <= rd;
      wreg_q    <= legal && rd != 5'd0;
      illegal_q <= !legal;
    end else if (drain) begin
      valid_q <= 1'b0;
      if (hazard && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid_o = valid_q;
  assign pc_o        = pc_q;
  assign aluop_o     = aluop_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign illegal_o   = illegal_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage with hand-encoded instructions
// and hand-computed ID/EX contents.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush_i, in_valid_i, in_ready_o, out_ready_i;
  logic [31:0] pc_i, inst_i, rs1_data_i, rs2_data_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [1:0]  fwd_wreg_i, fwd_is_load_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic        out_valid_o, wreg_o, illegal_o;
  logic [31:0] pc_o, op1_o, op2_o;
  logic [3:0]  aluop_o;
  logic [4:0]  wd_o;
  logic [15:0] stall_cnt_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rv_decode_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_is_load_i(fwd_is_load_i),
    .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .aluop_o(aluop_o), .op1_o(op1_o), .op2_o(op2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .illegal_o(illegal_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ORI   = 32'h0FF06293;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ADD0  = 32'h00200333;
  localparam logic [31:0] I_ADDX0 = 32'h00008233;
  localparam logic [31:0] I_SRAI  = 32'h4040D513;
  localparam logic [31:0] I_SLLIB = 32'h02309413;
  localparam logic [31:0] I_LUI   = 32'h123453B7;
  localparam logic [31:0] I_AUIPC = 32'h00001497;

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
    pc_i = 32'h0; inst_i = I_ADD;
    rs1_data_i = 32'h111; rs2_data_i = 32'h222;
    fwd_wreg_i = '0; fwd_is_load_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0;
    tick(); tick();
    chk("rst_in_ready", {31'b0, in_ready_o}, 32'd0);
    chk("rst_rs1_addr", {27'b0, rs1_addr_o}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_stall", {16'b0, stall_cnt_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    rst = 1'b0;

    // ori x5,x0,0xFF
    pc_i = 32'h10; inst_i = I_ORI; #1;
    chk("ori_in_ready", {31'b0, in_ready_o}, 32'd1);
    tick();
    chk("ori_valid", {31'b0, out_valid_o}, 32'd1);
    chk("ori_aluop", {28'b0, aluop_o}, 32'd9);
    chk("ori_op1", op1_o, 32'd0);
    chk("ori_op2", op2_o, 32'hFF);
    chk("ori_wd", {27'b0, wd_o}, 32'd5);
    chk("ori_wreg", {31'b0, wreg_o}, 32'd1);
    chk("ori_pc", pc_o, 32'h10);

    // add x3,x1,x2: both bypasses hit x1, index 0 wins
    pc_i = 32'h14; inst_i = I_ADD;
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1};
    fwd_wdata_i = {32'hB, 32'hA}; #1;
    chk("add_rs1_addr", {27'b0, rs1_addr_o}, 32'd1);
    chk("add_rs2_addr", {27'b0, rs2_addr_o}, 32'd2);
    tick();
    chk("add_op1_fwd0", op1_o, 32'hA);
    chk("add_op2_rf", op2_o, 32'h222);
    chk("add_aluop", {28'b0, aluop_o}, 32'd1);
    chk("add_wd", {27'b0, wd_o}, 32'd3);

    // add x6,x0,x2 with a wd=0 bypass on port 0
    inst_i = I_ADD0; fwd_wd_i = {5'd2, 5'd0};
    fwd_wdata_i = {32'h22, 32'hDEAD};
    tick();
    chk("x0_op1", op1_o, 32'd0);
    chk("x0_op2_fwd1", op2_o, 32'h22);

    // add x4,x1,x0 with load to x1 on port 0 -> bubble
    inst_i = I_ADDX0; fwd_wreg_i = 2'b01; fwd_is_load_i = 2'b01;
    fwd_wd_i = {5'd0, 5'd1}; #1;
    chk("lu_in_ready", {31'b0, in_ready_o}, 32'd0);
    tick();
    chk("lu_bubble", {31'b0, out_valid_o}, 32'd0);
    chk("lu_stall", {16'b0, stall_cnt_o}, 32'd1);
    // load data now available on port 1; port 0 is a load to x0
    fwd_wreg_i = 2'b11; fwd_is_load_i = 2'b01;
    fwd_wd_i = {5'd1, 5'd0}; fwd_wdata_i = {32'h55, 32'h0}; #1;
    chk("lu2_in_ready", {31'b0, in_ready_o}, 32'd1);
    tick();
    chk("lu2_valid", {31'b0, out_valid_o}, 32'd1);
    chk("lu2_op1", op1_o, 32'h55);
    chk("lu2_op2_x0", op2_o, 32'd0);
    chk("lu2_wd", {27'b0, wd_o}, 32'd4);
    chk("lu2_stall", {16'b0, stall_cnt_o}, 32'd1);

    // srai x10,x1,4 then backpressure with a hazard pending
    fwd_wreg_i = '0; fwd_is_load_i = '0;
    pc_i = 32'h20; inst_i = I_SRAI;
    tick();
    chk("srai_aluop", {28'b0, aluop_o}, 32'd8);
    chk("srai_op1", op1_o, 32'h111);
    chk("srai_op2", op2_o, 32'd4);
    chk("srai_wd", {27'b0, wd_o}, 32'd10);
    out_ready_i = 1'b0; inst_i = I_ADD; pc_i = 32'h24;
    fwd_wreg_i = 2'b01; fwd_is_load_i = 2'b01; fwd_wd_i = {5'd0, 5'd1};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'b0, in_ready_o}, 32'd0);
      tick();
      chk("bp_valid", {31'b0, out_valid_o}, 32'd1);
      chk("bp_pc", pc_o, 32'h20);
      chk("bp_op1", op1_o, 32'h111);
      chk("bp_stall", {16'b0, stall_cnt_o}, 32'd1);
    end
    out_ready_i = 1'b1;
    tick();
    chk("bp_rel_bubble", {31'b0, out_valid_o}, 32'd0);
    chk("bp_rel_stall", {16'b0, stall_cnt_o}, 32'd2);

    // flush while holding a valid instruction with another incoming
    fwd_wreg_i = '0; fwd_is_load_i = '0;
    pc_i = 32'h30; inst_i = I_ORI;
    tick();
    chk("fl_pre_valid", {31'b0, out_valid_o}, 32'd1);
    flush_i = 1'b1; pc_i = 32'h34; inst_i = I_LUI; #1;
    chk("fl_in_ready", {31'b0, in_ready_o}, 32'd0);
    tick();
    chk("fl_valid", {31'b0, out_valid_o}, 32'd0);
    flush_i = 1'b0; in_valid_i = 1'b0;
    tick();
    chk("fl_dropped", {31'b0, out_valid_o}, 32'd0);

    // slli with inst[25]=1, then lui, then auipc
    in_valid_i = 1'b1; pc_i = 32'h40; inst_i = I_SLLIB;
    tick();
    chk("slli_valid", {31'b0, out_valid_o}, 32'd1);
    chk("slli_illegal", {31'b0, illegal_o}, 32'd1);
    chk("slli_wreg", {31'b0, wreg_o}, 32'd0);
    chk("slli_aluop", {28'b0, aluop_o}, 32'd0);
    inst_i = I_LUI;
    tick();
    chk("lui_illegal", {31'b0, illegal_o}, 32'd0);
    chk("lui_op1", op1_o, 32'd0);
    chk("lui_op2", op2_o, 32'h12345000);
    chk("lui_aluop", {28'b0, aluop_o}, 32'd1);
    chk("lui_wd", {27'b0, wd_o}, 32'd7);
    chk("lui_wreg", {31'b0, wreg_o}, 32'd1);
    pc_i = 32'h100; inst_i = I_AUIPC;
    tick();
    chk("auipc_op1", op1_o, 32'h100);
    chk("auipc_op2", op2_o, 32'h1000);
    chk("auipc_wd", {27'b0, wd_o}, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
